// File: rtl/mips_alu_unit_pkg.sv
// rtl/mips_alu_unit_pkg.sv - shared opcode/funct constants, class codes and ALU op enum
package mips_alu_unit_pkg;

  // ALU class codes from the main decoder
  localparam logic [1:0] CLS_ADD    = 2'b00;
  localparam logic [1:0] CLS_BRANCH = 2'b01;
  localparam logic [1:0] CLS_RTYPE  = 2'b10;
  localparam logic [1:0] CLS_ITYPE  = 2'b11;

  // Instruction opcodes [31:26]
  localparam logic [5:0] OPC_REGIMM = 6'b000001;
  localparam logic [5:0] OPC_BLEZ   = 6'b000110;
  localparam logic [5:0] OPC_BGTZ   = 6'b000111;
  localparam logic [5:0] OPC_ADDIU  = 6'b001001;
  localparam logic [5:0] OPC_SLTI   = 6'b001010;
  localparam logic [5:0] OPC_SLTIU  = 6'b001011;
  localparam logic [5:0] OPC_ANDI   = 6'b001100;
  localparam logic [5:0] OPC_ORI    = 6'b001101;
  localparam logic [5:0] OPC_XORI   = 6'b001110;
  localparam logic [5:0] OPC_LUI    = 6'b001111;

  // R-type funct codes [5:0]
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // Sixteen ops fill the 4-bit code exactly, so MTHI and MTLO share OP_MT;
  // the datapath picks HI vs LO from funct bit 1 (MTHI=...01, MTLO=...11).
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLL,
    OP_SRL, OP_SRA, OP_LUI, OP_MFHI, OP_MFLO, OP_MT, OP_MUL, OP_DIV
  } alu_op_e;

  // Branches against zero carry an offset in imm, so B must be forced to 0
  function automatic logic is_zero_cmp(input logic [5:0] opc);
    return (opc == OPC_REGIMM) || (opc == OPC_BLEZ) || (opc == OPC_BGTZ);
  endfunction

endpackage

// File: rtl/mips_alu_unit_if.sv
// rtl/mips_alu_unit_if.sv - operand/control/result bundle between decoder side and ALU
interface mips_alu_unit_if;
  logic        clk_enable;
  logic [31:0] alua_in;
  logic [31:0] reg_b;
  logic [31:0] imm;
  logic        alusrc;
  logic [5:0]  insop;
  logic [5:0]  func;
  logic [1:0]  alucwire;
  logic        unsign;
  logic [31:0] aluout;
  logic        eq;
  logic        lt;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output clk_enable, alua_in, reg_b, imm, alusrc, insop, func, alucwire, unsign,
    input  aluout, eq, lt, hi, lo
  );

  modport slave (
    input  clk_enable, alua_in, reg_b, imm, alusrc, insop, func, alucwire, unsign,
    output aluout, eq, lt, hi, lo
  );
endinterface

// File: rtl/mips_alu_unit_decode.sv
// rtl/mips_alu_unit_decode.sv - maps class/opcode/funct to the 4-bit ALU op
module mips_alu_decode
  import mips_alu_unit_pkg::*;
(
  input  logic [1:0] alucwire,
  input  logic [5:0] insop,
  input  logic [5:0] func,
  output alu_op_e    op
);

  // Class selects fixed op, funct decode or opcode decode; unknown codes fall back to ADD
  always_comb begin
    op = OP_ADD;
    case (alucwire)
      CLS_ADD:    op = OP_ADD;
      CLS_BRANCH: op = OP_SUB;
      CLS_RTYPE: begin
        case (func)
          FN_ADDU, FN_JR, FN_JALR:  op = OP_ADD;
          FN_SUBU:                  op = OP_SUB;
          FN_AND:                   op = OP_AND;
          FN_OR:                    op = OP_OR;
          FN_XOR:                   op = OP_XOR;
          FN_NOR:                   op = OP_NOR;
          FN_SLT, FN_SLTU:          op = OP_SLT;
          FN_SLL, FN_SLLV:          op = OP_SLL;
          FN_SRL, FN_SRLV:          op = OP_SRL;
          FN_SRA, FN_SRAV:          op = OP_SRA;
          FN_MFHI:                  op = OP_MFHI;
          FN_MFLO:                  op = OP_MFLO;
          FN_MTHI, FN_MTLO:         op = OP_MT;
          FN_MULT, FN_MULTU:        op = OP_MUL;
          FN_DIV, FN_DIVU:          op = OP_DIV;
          default:                  op = OP_ADD;
        endcase
      end
      CLS_ITYPE: begin
        case (insop)
          OPC_ADDIU:            op = OP_ADD;
          OPC_SLTI, OPC_SLTIU:  op = OP_SLT;
          OPC_ANDI:             op = OP_AND;
          OPC_ORI:              op = OP_OR;
          OPC_XORI:             op = OP_XOR;
          OPC_LUI:              op = OP_LUI;
          default:              op = OP_ADD;
        endcase
      end
      default: op = OP_ADD;
    endcase
  end

endmodule

// File: rtl/mips_alu_unit.sv
// rtl/mips_alu_unit.sv - MIPS ALU datapath with HI/LO multiply/divide registers
module mips_alu_unit
  import mips_alu_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mips_alu_unit_if.slave alu
);

  alu_op_e     op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        lt;
  logic [31:0] result;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  mips_alu_decode u_decode (
    .alucwire (alu.alucwire),
    .insop    (alu.insop),
    .func     (alu.func),
    .op       (op)
  );

  assign a     = alu.alua_in;
  assign b     = alu.alusrc ? (is_zero_cmp(alu.insop) ? 32'h0 : alu.imm) : alu.reg_b;
  assign shamt = a[4:0];
  assign lt    = alu.unsign ? (a < b) : ($signed(a) < $signed(b));

  // Operands widened to 64 bits so one multiplier serves MULT and MULTU
  assign a_ext = alu.unsign ? {32'h0, a} : {{32{a[31]}}, a};
  assign b_ext = alu.unsign ? {32'h0, b} : {{32{b[31]}}, b};
  assign prod  = a_ext * b_ext;

  // Quotient/remainder; the B=0 result is never committed
  always_comb begin
    quot = 32'h0;
    rem  = 32'h0;
    if (b != 32'h0) begin
      if (alu.unsign) begin
        quot = a / b;
        rem  = a % b;
      end else begin
        quot = $unsigned($signed(a) / $signed(b));
        rem  = $unsigned($signed(a) % $signed(b));
      end
    end
  end

  // Combinational result select
  always_comb begin
    result = 32'h0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = {31'h0, lt};
      OP_SLL:  result = b << shamt;
      OP_SRL:  result = b >> shamt;
      OP_SRA:  result = $unsigned($signed(b) >>> shamt);
      OP_LUI:  result = {b[15:0], 16'h0};
      OP_MFHI: result = hi_q;
      OP_MFLO: result = lo_q;
      default: result = 32'h0;
    endcase
  end

  // HI/LO next state; anything other than MUL, DIV (B!=0) or MT holds
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (alu.clk_enable) begin
      case (op)
        OP_MUL: begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
        OP_DIV: begin
          if (b != 32'h0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
        OP_MT: begin
          if (alu.func[1]) lo_d = a;
          else             hi_d = a;
        end
        default: ;
      endcase
    end
  end

  // HI/LO registers; reset wins over any write
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign alu.aluout = result;
  assign alu.eq     = (a == b);
  assign alu.lt     = lt;
  assign alu.hi     = hi_q;
  assign alu.lo     = lo_q;

endmodule

// File: tb/tb_mips_alu_unit.sv
// tb/tb_mips_alu_unit.sv - directed self-checking bench for mips_alu_unit
module tb_mips_alu_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mips_alu_unit_if bus ();

  mips_alu_unit dut (
    .clk   (clk),
    .reset (reset),
    .alu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] cls, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] rb, input logic [31:0] im,
                       input logic src, input logic uns, input logic en);
    @(negedge clk);
    bus.alucwire   = cls;
    bus.insop      = opc;
    bus.func       = fn;
    bus.alua_in    = a;
    bus.reg_b      = rb;
    bus.imm        = im;
    bus.alusrc     = src;
    bus.unsign     = uns;
    bus.clk_enable = en;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(2'b10, 6'd0, 6'b011000, 32'h5, 32'h7, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=%h", bus.hi, 32'h0); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=%h", bus.lo, 32'h0); end
    reset = 1'b0;
  endtask

  task automatic test_addu();
    drive(2'b10, 6'd0, 6'b100001, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'h80000000) begin bad++; $display("FAIL addu got=%h want=%h", bus.aluout, 32'h80000000); end
    drive(2'b00, 6'b100011, 6'd0, 32'h100, 32'h0, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'h000000FC) begin bad++; $display("FAIL ldst_addr got=%h want=%h", bus.aluout, 32'hFC); end
    drive(2'b10, 6'd0, 6'b001000, 32'h00400010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'h00400010) begin bad++; $display("FAIL jr got=%h want=%h", bus.aluout, 32'h00400010); end
    drive(2'b10, 6'd0, 6'b100011, 32'h5, 32'h7, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'hFFFFFFFE) begin bad++; $display("FAIL subu got=%h want=%h", bus.aluout, 32'hFFFFFFFE); end
  endtask

  task automatic test_slt();
    drive(2'b10, 6'd0, 6'b101010, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'h1) begin bad++; $display("FAIL slt_out got=%h want=%h", bus.aluout, 32'h1); end
    total++; if (bus.lt !== 1'b1) begin bad++; $display("FAIL slt_lt got=%b want=1", bus.lt); end
    drive(2'b10, 6'd0, 6'b101011, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);
    total++; if (bus.aluout !== 32'h0) begin bad++; $display("FAIL sltu_out got=%h want=%h", bus.aluout, 32'h0); end
    total++; if (bus.lt !== 1'b0) begin bad++; $display("FAIL sltu_lt got=%b want=0", bus.lt); end
    drive(2'b11, 6'b001010, 6'd0, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF8, 1'b1, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'h1) begin bad++; $display("FAIL slti got=%h want=%h", bus.aluout, 32'h1); end
  endtask

  task automatic test_branch_b();
    drive(2'b01, 6'b000111, 6'd0, 32'h5, 32'h99, 32'h10, 1'b1, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'h5) begin bad++; $display("FAIL bgtz_out got=%h want=%h", bus.aluout, 32'h5); end
    total++; if (bus.eq !== 1'b0) begin bad++; $display("FAIL bgtz_eq got=%b want=0", bus.eq); end
    total++; if (bus.lt !== 1'b0) begin bad++; $display("FAIL bgtz_lt got=%b want=0", bus.lt); end
    drive(2'b01, 6'b000111, 6'd0, 32'h0, 32'h99, 32'h10, 1'b1, 1'b0, 1'b0);
    total++; if (bus.eq !== 1'b1) begin bad++; $display("FAIL bgtz_eq0 got=%b want=1", bus.eq); end
    drive(2'b01, 6'b000100, 6'd0, 32'h10, 32'h99, 32'h10, 1'b1, 1'b0, 1'b0);
    total++; if (bus.eq !== 1'b1) begin bad++; $display("FAIL beq_imm_eq got=%b want=1", bus.eq); end
    drive(2'b01, 6'b000100, 6'd0, 32'h3, 32'h9, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.lt !== 1'b1 || bus.eq !== 1'b0) begin bad++; $display("FAIL regb_cmp got lt=%b eq=%b want lt=1 eq=0", bus.lt, bus.eq); end
  endtask

  task automatic test_logic_shift();
    drive(2'b11, 6'b001100, 6'd0, 32'h0000F0F0, 32'h0, 32'h0000FF00, 1'b1, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'h0000F000) begin bad++; $display("FAIL andi got=%h want=%h", bus.aluout, 32'h0000F000); end
    drive(2'b11, 6'b001111, 6'd0, 32'h0, 32'h0, 32'h00001234, 1'b1, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'h12340000) begin bad++; $display("FAIL lui got=%h want=%h", bus.aluout, 32'h12340000); end
    drive(2'b11, 6'b111111, 6'd0, 32'h10, 32'h0, 32'h5, 1'b1, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'h15) begin bad++; $display("FAIL itype_default got=%h want=%h", bus.aluout, 32'h15); end
    drive(2'b10, 6'd0, 6'b100111, 32'h0F0F0000, 32'h000000FF, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'hF0F0FF00) begin bad++; $display("FAIL nor got=%h want=%h", bus.aluout, 32'hF0F0FF00); end
    drive(2'b10, 6'd0, 6'b000000, 32'h4, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'h10) begin bad++; $display("FAIL sll got=%h want=%h", bus.aluout, 32'h10); end
    drive(2'b10, 6'd0, 6'b000110, 32'h24, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'h08000000) begin bad++; $display("FAIL srlv got=%h want=%h", bus.aluout, 32'h08000000); end
  endtask

  task automatic test_mult();
    drive(2'b10, 6'd0, 6'b011000, 32'hFFFFFFFE, 32'h3, 32'h0, 1'b0, 1'b0, 1'b1);
    total++; if (bus.aluout !== 32'h0) begin bad++; $display("FAIL mult_out got=%h want=%h", bus.aluout, 32'h0); end
    @(posedge clk); #1;
    total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h want=%h", bus.hi, 32'hFFFFFFFF); end
    total++; if (bus.lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo got=%h want=%h", bus.lo, 32'hFFFFFFFA); end
    drive(2'b10, 6'd0, 6'b010010, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    total++; if (bus.aluout !== 32'hFFFFFFFA) begin bad++; $display("FAIL mflo got=%h want=%h", bus.aluout, 32'hFFFFFFFA); end
    drive(2'b10, 6'd0, 6'b011001, 32'hFFFFFFFE, 32'h3, 32'h0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    total++; if (bus.hi !== 32'h2 || bus.lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL multu got hi=%h lo=%h want hi=2 lo=fffffffa", bus.hi, bus.lo); end
    drive(2'b10, 6'd0, 6'b010000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    total++; if (bus.aluout !== 32'h2) begin bad++; $display("FAIL mfhi got=%h want=%h", bus.aluout, 32'h2); end
  endtask

  task automatic test_div();
    drive(2'b10, 6'd0, 6'b011010, 32'hFFFFFFF9, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++; if (bus.lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h want=%h", bus.lo, 32'hFFFFFFFD); end
    total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h want=%h", bus.hi, 32'hFFFFFFFF); end
    drive(2'b10, 6'd0, 6'b011010, 32'h64, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++; if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div0_hold got hi=%h lo=%h want hi=ffffffff lo=fffffffd", bus.hi, bus.lo); end
    drive(2'b10, 6'd0, 6'b011011, 32'hFFFFFFF9, 32'h2, 32'h0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    total++; if (bus.lo !== 32'h7FFFFFFC || bus.hi !== 32'h1) begin bad++; $display("FAIL divu got hi=%h lo=%h want hi=1 lo=7ffffffc", bus.hi, bus.lo); end
  endtask

  task automatic test_mt_enable_reset();
    drive(2'b10, 6'd0, 6'b010001, 32'hABCD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    total++; if (bus.hi !== 32'h1) begin bad++; $display("FAIL enable_hold got=%h want=%h", bus.hi, 32'h1); end
    drive(2'b10, 6'd0, 6'b010001, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++; if (bus.hi !== 32'h1234 || bus.lo !== 32'h7FFFFFFC) begin bad++; $display("FAIL mthi got hi=%h lo=%h want hi=1234 lo=7ffffffc", bus.hi, bus.lo); end
    drive(2'b10, 6'd0, 6'b010011, 32'h5678, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin bad++; $display("FAIL reset_vs_mtlo got hi=%h lo=%h want 0 0", bus.hi, bus.lo); end
    drive(2'b10, 6'd0, 6'b010011, 32'h5678, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++; if (bus.lo !== 32'h5678 || bus.hi !== 32'h0) begin bad++; $display("FAIL mtlo got hi=%h lo=%h want hi=0 lo=5678", bus.hi, bus.lo); end
  endtask

  task automatic test_sra();
    drive(2'b10, 6'd0, 6'b000011, 32'h4, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'hF8000000) begin bad++; $display("FAIL sra got=%h want=%h", bus.aluout, 32'hF8000000); end
    drive(2'b10, 6'd0, 6'b000010, 32'h4, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.aluout !== 32'h08000000) begin bad++; $display("FAIL srl got=%h want=%h", bus.aluout, 32'h08000000); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.clk_enable = 1'b0;
    bus.alua_in    = 32'h0;
    bus.reg_b      = 32'h0;
    bus.imm        = 32'h0;
    bus.alusrc     = 1'b0;
    bus.insop      = 6'd0;
    bus.func       = 6'd0;
    bus.alucwire   = 2'b00;
    bus.unsign     = 1'b0;
    test_reset();
    test_addu();
    test_slt();
    test_branch_b();
    test_logic_shift();
    test_mult();
    test_div();
    test_mt_enable_reset();
    test_sra();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_alu_unit.md
MIPS_ALU_UNIT -- requirements
Module: mips_alu_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 clk  in  1  rising-edge clock for the HI/LO registers.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 clk_enable  in  1  HI/LO write qualifier; 0 freezes the state.
REQ-005 alua_in  in  32  operand A; for shifts, the amount in bits [4:0].
REQ-006 reg_b  in  32  register operand B (rt).
REQ-007 imm  in  32  already extended immediate.
REQ-008 alusrc  in  1  1 selects the immediate path for B; 0 selects reg_b.
REQ-009 insop  in  6  instruction opcode [31:26].
REQ-010 func  in  6  instruction funct [5:0].
REQ-011 alucwire  in  2  class: 00 add (load/store), 01 branch compare, 10 R-type (decode func), 11 I-type ALU (decode insop).
REQ-012 unsign  in  1  1 selects unsigned compare, multiply and divide.
REQ-013 aluout  out  32  combinational result.
REQ-014 eq  out  1  A equals final B.
REQ-015 lt  out  1  A less than final B, signed or unsigned per unsign.
REQ-016 hi, lo  out  32 each  registered HI/LO values.

Function
REQ-017 Final B SHALL be reg_b when alusrc=0; when alusrc=1 it SHALL be zero for insop 000001/000110/000111 (REGIMM, BLEZ, BGTZ) and imm otherwise.
REQ-018 The 4-bit op decode: class 00 gives ADD; class 01 gives SUB; class 10 maps funct: ADDU/JR/JALR to ADD (JR/JALR pass A plus 0); SUBU to SUB; AND, OR, XOR, NOR; SLT/SLTU to SLT; SLL/SLLV to SLL; SRL/SRLV to SRL; SRA/SRAV to SRA; MFHI, MFLO, MTHI, MTLO; MULT/MULTU to MUL; DIV/DIVU to DIV.
REQ-019 Class 11 SHALL map insop ADDIU to ADD, SLTI/SLTIU to SLT, ANDI to AND, ORI to OR, XORI to XOR, and LUI to LUI; unknown codes SHALL yield ADD.
REQ-020 Results: ADD is A+B and SUB is A-B, both modulo 2^32 with no overflow trap; AND, OR, XOR and NOR are bitwise.
REQ-021 SLT SHALL return the 32-bit value lt (0 or 1).
REQ-022 Shift results: SLL is B<<A[4:0], SRL is B>>A[4:0] (logical), SRA is B>>>A[4:0] (arithmetic).
REQ-023 LUI SHALL return {B[15:0],16'h0}.
REQ-024 MFHI SHALL return hi and MFLO SHALL return lo; MUL, DIV, MTHI and MTLO SHALL return 0.
REQ-025 eq and lt SHALL be computed combinationally for every op, using A and final B.
REQ-026 On a rising clk with clk_enable=1, MUL SHALL load {hi,lo} with the 64-bit product of A and B, signed or unsigned per unsign.
REQ-027 On the same conditions, DIV SHALL load lo with the quotient and hi with the remainder: signed quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-028 DIV with B=0 SHALL leave hi and lo unchanged.
REQ-029 On the same conditions, MTHI SHALL load hi with A and MTLO SHALL load lo with A; all other ops SHALL hold hi and lo.
REQ-030 Latency SHALL be zero for aluout, eq and lt; hi and lo SHALL be visible one cycle after the write edge.

Reset
REQ-031 reset=1 at a rising clk SHALL clear hi and lo to 0, taking precedence over clk_enable and any write op.
REQ-032 Combinational outputs SHALL be unaffected by reset except through hi and lo.

Structure
REQ-033 A shared package SHALL hold the opcode and funct constants, the 2-bit class codes, and the 4-bit ALU op enum.
REQ-034 The op decode SHALL be one sub-module, mips_alu_decode (inputs alucwire, insop, func; output the op enum); datapath and HI/LO SHALL stay in the top.

Verification
REQ-035 A=0x7FFFFFFF, reg_b=1, class 10, funct ADDU -> aluout=0x80000000, no trap.
REQ-036 A=0xFFFFFFFF, reg_b=1, funct SLT -> aluout=1, lt=1; same operands with SLTU and unsign=1 -> aluout=0, lt=0.
REQ-037 alusrc=1, insop BGTZ, imm=0x10, A=5, class 01 -> final B=0, eq=0, lt=0; A=0 -> eq=1.
REQ-038 MULT with A=0xFFFFFFFE, B=3, clk_enable=1, one edge -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; then MFLO -> aluout=0xFFFFFFFA.
REQ-039 DIV with A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV with B=0 -> hi and lo unchanged.
REQ-040 MTHI A=0x1234, then reset asserted on the next edge together with MTLO -> hi=lo=0; funct SRA, A=4, reg_b=0x80000000 -> 0xF8000000.
